vga_scan_out: RTL

VGA_SCAN_OUT -- requirements
Module: vga_scan_out

---
 rtl/vga_scan_out.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_scan_out.sv
// vga_scan_out
//   VGA raster timing generator and pixel scan-out. A free-running h/v
//   counter pair produces the raster; a WAIT_SOF/RUN state machine locks
//   the upstream pixel stream to the raster on the first pixel of a frame.
//   Loss of lock raises a sticky underflow flag. Lock is lost on a missing
//   pixel, or on an SOF that arrives at the wrong raster position. While
//   unlocked the block shows black and waits for the next SOF at (0,0).
//
//   Optional feature: define VGA_TEST_PAT_EN to add the test_pat input and
//   the 8-bar colour test pattern. Without it, the port and logic are absent.
//
// Ports
//   clk, reset       pixel clock, async active-high reset
//   pix_data         upstream pixel {R,G,B}
//   pix_sof          first pixel of frame
//   pix_valid        upstream pixel valid
//   pix_ready        pixel consumed this cycle when pix_valid is also high
//   clr_underflow    clears underflow (a set in the same cycle wins)
//   underflow        sticky lock-loss flag
//   frame_start      one-cycle pulse aligned with the outputs of pixel (0,0)
//   vga_r/g/b        registered colour, black outside the active region
//   vga_hs, vga_vs   registered syncs, active-low
//   vga_blank_n      registered, high in the active region
//   vga_sync_n       tied low
//   test_pat         (VGA_TEST_PAT_EN only) show colour bars, stall upstream
module vga_scan_out #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] pix_data,
   input  logic        pix_sof,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic        clr_underflow,
`ifdef VGA_TEST_PAT_EN
   input  logic        test_pat,
`endif
   output logic        underflow,
   output logic        frame_start,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        vga_sync_n
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic {WAIT_SOF = 1'b0, RUN = 1'b1} state_t;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   state_t        state_q, state_d;
   logic          active, at_origin, misalign;
   logic          uf_set, ready_c, show;
   logic          tp_on;
   rgb_t          rgb_d, rgb_q;

   // ---------------- raster counters ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign at_origin = (h_cnt == '0) && (v_cnt == '0);
   // An SOF anywhere but (0,0) means upstream and raster disagree.
   assign misalign  = pix_valid && pix_sof && !at_origin;

`ifdef VGA_TEST_PAT_EN
   // Eight equal bars across the active width; R/G/B are each a single
   // bit of the bar index (white, yellow, cyan, green, magenta, red, blue, black).
   localparam int BAR_W = H_ACTIVE / 8;
   logic [HW-1:0] bar_num;
   logic [2:0]    bar_idx;
   assign tp_on   = test_pat;
   assign bar_num = h_cnt / HW'(BAR_W);
   assign bar_idx = (bar_num > HW'(7)) ? 3'd7 : bar_num[2:0];
`else
   assign tp_on = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= WAIT_SOF;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   // Test pattern freezes the lock state and the flag.
   always_comb begin
      state_d = state_q;
      uf_set  = 1'b0;
      if (!tp_on) begin
         case (state_q)
            WAIT_SOF: if (pix_valid && pix_sof && at_origin) state_d = RUN;
            RUN: if (active && (!pix_valid || misalign)) begin
               state_d = WAIT_SOF;
               uf_set  = 1'b1;
            end
            default: state_d = WAIT_SOF;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   // WAIT_SOF drains non-SOF pixels so the next SOF reaches the head of
   // the stream, then holds that SOF until the raster is at (0,0).
   always_comb begin
      ready_c = 1'b0;
      show    = 1'b0;
      if (!tp_on) begin
         case (state_q)
            WAIT_SOF: begin
               ready_c = pix_valid && (!pix_sof || at_origin);
               show    = pix_valid && pix_sof && at_origin;
            end
            RUN: begin
               ready_c = active && !misalign;
               show    = active && pix_valid && !misalign;
            end
            default: ;
         endcase
      end
   end

   assign pix_ready = ready_c && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)              underflow <= 1'b0;
      else if (uf_set)        underflow <= 1'b1;
      else if (clr_underflow && !tp_on) underflow <= 1'b0;
   end

   // ---------------- colour select ----------------
   always_comb begin
      rgb_d = '0;
      if (show) rgb_d = rgb_t'(pix_data);
`ifdef VGA_TEST_PAT_EN
      if (tp_on && active)
         rgb_d = rgb_t'({{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}});
`endif
   end

   // ---------------- registered VGA outputs ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb_q       <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         rgb_q       <= rgb_d;
         vga_hs      <= !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
         vga_vs      <= !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
         vga_blank_n <= active;
         frame_start <= at_origin;
      end
   end

   assign vga_r      = rgb_q.r;
   assign vga_g      = rgb_q.g;
   assign vga_b      = rgb_q.b;
   assign vga_sync_n = 1'b0;

endmodule
